pwm_peripheral: RTL and testbench

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_peripheral_pkg.sv | 13 +
 rtl/pwm_prescaler.sv | 33 +++
 rtl/pwm_peripheral.sv | 64 ++++++
 tb/tb_pwm_peripheral.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_peripheral_pkg.sv
// Shared constants and the duty compare used by the PWM peripheral.
package pwm_peripheral_pkg;

  localparam logic [7:0]  PWM_CNT_MAX      = 8'd254;
  localparam logic [7:0]  DUTY_FULL        = 8'hFF;
  localparam int unsigned PRESCALE_DEFAULT = 16;

  // Full-scale duty is forced high so the output never drops at the 254->0 wrap.
  function automatic logic pwm_compare(input logic [7:0] cnt, input logic [7:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE cycles.
module pwm_prescaler
  import pwm_peripheral_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [15:0] PreLast = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt_q, pre_cnt_d;

  assign tick = (pre_cnt_q == PreLast);

  always_comb begin
    pre_cnt_d = pre_cnt_q + 16'd1;
    if (tick) begin
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM block: free-running 255-tick period, shadowed shared duty,
// per-channel enable / static-high / PWM selection with registered outputs.
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] en_out,
  input  logic [15:0] en_pwm_mode,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out
);

  logic        tick;
  logic        wrap;
  logic        pwm_level;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] pwm_out_q, pwm_out_d;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign wrap      = tick && (pwm_cnt_q == PWM_CNT_MAX);
  assign pwm_level = pwm_compare(pwm_cnt_q, duty_q);

  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    if (wrap) begin
      pwm_cnt_d = '0;
      // Duty is only sampled at the period boundary so a period is never torn.
      duty_d    = pwm_duty_cycle;
    end else if (tick) begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end
  end

  always_comb begin
    pwm_out_d = en_out & (~en_pwm_mode | {16{pwm_level}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      pwm_out_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scenario bench for pwm_peripheral with PRESCALE = 4 (1020-clk period).
module tb_pwm_peripheral;

  localparam int unsigned PRESCALE = 4;
  localparam int          PERIOD   = 255 * PRESCALE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm_mode = '0;
  logic [7:0]  pwm_duty_cycle = '0;
  logic [15:0] pwm_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pwm_peripheral #(
    .PRESCALE (PRESCALE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_out         (en_out),
    .en_pwm_mode    (en_pwm_mode),
    .pwm_duty_cycle (pwm_duty_cycle),
    .pwm_out        (pwm_out)
  );

  // Counts consecutive negedge samples of channel 0 at lvl; also counts samples
  // where the 16 channels disagree.
  task automatic measure_width(input logic lvl, input int limit, output int width,
                               output int mixed);
    width = 0;
    mixed = 0;
    while (pwm_out[0] === lvl && width < limit) begin
      if (pwm_out !== 16'h0000 && pwm_out !== 16'hFFFF) mixed++;
      width++;
      @(negedge clk);
    end
  endtask

  task automatic wait_level(input logic lvl, input int limit, output bit ok);
    int n;
    n = 0;
    while (pwm_out[0] !== lvl && n < limit) begin
      n++;
      @(negedge clk);
    end
    ok = (pwm_out[0] === lvl);
  endtask

  task automatic test_reset();
    logic [31:0] e;
    int          bad;
    en_out         = 16'($urandom);
    en_pwm_mode    = 16'($urandom);
    pwm_duty_cycle = 8'($urandom);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({16'h0, pwm_out} !== e) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", pwm_out, e[15:0]);
    end
    en_out         = '0;
    pwm_duty_cycle = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'd0);
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (pwm_out !== 16'h0000) bad++;
    end
    e = exp_q.pop_front();
    checks++;
    if (32'(bad) !== e) begin
      errors++;
      $display("FAIL reset_idle: %0d nonzero cycles, expected %0d", bad, e);
    end
  endtask

  task automatic test_static();
    logic [31:0] e;
    @(negedge clk);
    en_out      = 16'h0001;
    en_pwm_mode = 16'h0000;
    exp_q.push_back(32'h0000);
    exp_q.push_back(32'h0001);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({16'h0, pwm_out} !== e) begin
      errors++;
      $display("FAIL static_on_early: got %h expected %h", pwm_out, e[15:0]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({16'h0, pwm_out} !== e) begin
      errors++;
      $display("FAIL static_on: got %h expected %h", pwm_out, e[15:0]);
    end
    en_out = 16'h0000;
    exp_q.push_back(32'h0001);
    exp_q.push_back(32'h0000);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({16'h0, pwm_out} !== e) begin
      errors++;
      $display("FAIL static_off_early: got %h expected %h", pwm_out, e[15:0]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({16'h0, pwm_out} !== e) begin
      errors++;
      $display("FAIL static_off: got %h expected %h", pwm_out, e[15:0]);
    end
  endtask

  task automatic test_pwm_half();
    logic [31:0] e;
    bit          ok;
    int          hi, lo, mx_hi, mx_lo;
    pwm_duty_cycle = 8'h80;
    en_out         = 16'hFFFF;
    en_pwm_mode    = 16'hFFFF;
    wait_level(1'b1, PERIOD + 80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL half_start: got no rising edge, expected one within %0d clk", PERIOD + 80);
    end
    exp_q.push_back(32'd512);
    exp_q.push_back(32'd508);
    exp_q.push_back(32'(PERIOD));
    exp_q.push_back(32'd0);
    measure_width(1'b1, 2 * PERIOD, hi, mx_hi);
    measure_width(1'b0, 2 * PERIOD, lo, mx_lo);
    e = exp_q.pop_front();
    checks++;
    if (32'(hi) !== e) begin
      errors++;
      $display("FAIL half_high: got %0d clk expected %0d", hi, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (32'(lo) !== e) begin
      errors++;
      $display("FAIL half_low: got %0d clk expected %0d", lo, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (32'(hi + lo) !== e) begin
      errors++;
      $display("FAIL half_period: got %0d clk expected %0d", hi + lo, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (32'(mx_hi + mx_lo) !== e) begin
      errors++;
      $display("FAIL half_aligned: %0d mixed samples expected %0d", mx_hi + mx_lo, e);
    end
  endtask

  task automatic test_duty_extremes();
    logic [31:0] e;
    bit          ok;
    int          cnt;
    pwm_duty_cycle = 8'h00;
    wait_level(1'b0, PERIOD + 80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_start: got no falling edge, expected one within %0d clk", PERIOD + 80);
    end
    exp_q.push_back(32'd0);
    cnt = 0;
    repeat (3 * PERIOD + 600) begin
      @(negedge clk);
      if (pwm_out !== 16'h0000) cnt++;
    end
    e = exp_q.pop_front();
    checks++;
    if (32'(cnt) !== e) begin
      errors++;
      $display("FAIL zero_low: got %0d non-low cycles expected %0d", cnt, e);
    end
    pwm_duty_cycle = 8'hFF;
    wait_level(1'b1, PERIOD + 80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_start: got no rising edge, expected one within %0d clk", PERIOD + 80);
    end
    exp_q.push_back(32'd0);
    cnt = 0;
    repeat (3 * PERIOD + 600) begin
      @(negedge clk);
      if (pwm_out !== 16'hFFFF) cnt++;
    end
    e = exp_q.pop_front();
    checks++;
    if (32'(cnt) !== e) begin
      errors++;
      $display("FAIL full_high: got %0d non-high cycles expected %0d", cnt, e);
    end
  endtask

  task automatic test_duty_change();
    logic [31:0] e;
    bit          ok;
    int          w, rest, lo, hi2, mx;
    pwm_duty_cycle = 8'h40;
    wait_level(1'b0, 2 * PERIOD, ok);
    if (ok) wait_level(1'b1, PERIOD, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL change_sync: got no 0x40 period start, expected one within %0d clk",
               3 * PERIOD);
    end
    exp_q.push_back(32'd256);
    exp_q.push_back(32'd764);
    exp_q.push_back(32'd768);
    // 41 samples past the first high sample lands mid-way through pwm_cnt == 10.
    w = 0;
    repeat (41) begin
      if (pwm_out[0] === 1'b1) w++;
      @(negedge clk);
    end
    pwm_duty_cycle = 8'hC0;
    measure_width(1'b1, 2 * PERIOD, rest, mx);
    w += rest;
    measure_width(1'b0, 2 * PERIOD, lo, mx);
    measure_width(1'b1, 2 * PERIOD, hi2, mx);
    e = exp_q.pop_front();
    checks++;
    if (32'(w) !== e) begin
      errors++;
      $display("FAIL change_cur_high: got %0d clk expected %0d", w, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (32'(lo) !== e) begin
      errors++;
      $display("FAIL change_cur_low: got %0d clk expected %0d", lo, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (32'(hi2) !== e) begin
      errors++;
      $display("FAIL change_next_high: got %0d clk expected %0d", hi2, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    bit          ok;
    int          lo, hi, mx;
    pwm_duty_cycle = 8'h80;
    wait_level(1'b1, 2 * PERIOD, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_sync: got no high phase, expected one within %0d clk", 2 * PERIOD);
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({16'h0, pwm_out} !== e) begin
      errors++;
      $display("FAIL mid_async: got %h expected %h", pwm_out, e[15:0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'(PERIOD));
    exp_q.push_back(32'd512);
    @(negedge clk);
    measure_width(1'b0, 2 * PERIOD, lo, mx);
    measure_width(1'b1, 2 * PERIOD, hi, mx);
    e = exp_q.pop_front();
    checks++;
    if (32'(lo) !== e) begin
      errors++;
      $display("FAIL mid_first_low: got %0d clk expected %0d", lo, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (32'(hi) !== e) begin
      errors++;
      $display("FAIL mid_first_high: got %0d clk expected %0d", hi, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_static();
    test_pwm_half();
    test_duty_extremes();
    test_duty_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
